uart_tx_drain: RTL and testbench

Downstream consumer of the 16-deep byte FIFO. It pops one byte whenever the FIFO is non-empty and the line is idle, then serialises it as an 8N1 UART frame (start bit, 8 data bits LSB first, stop bit) on a single tx pin. It is the transmit back-end of the processor's serial output path.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_cnt.sv | 39 +++
 rtl/uart_tx_drain.sv | 132 +++++++++++++
 tb/tb_uart_tx_drain.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit drain.
// UART_TX_PARITY_EN adds an even-parity bit between data and stop.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd4,
`endif
      STOP   = 3'd5
   } state_e;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while running.
// pre_end_o flags the cycle before bit_end_o so callers can register pulses.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic run_i,
   output logic bit_end_o,
   output logic pre_end_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign bit_end_o = run_i & (cnt_q == CW'(CLKS_PER_BIT - 1));
   assign pre_end_o = run_i & (cnt_q == CW'(CLKS_PER_BIT - 2));

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (run_i) begin
         cnt_d = bit_end_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_drain.sv
// FIFO-draining 8N1 UART transmitter with registered line outputs.
// Define UART_TX_PARITY_EN for an even-parity bit before stop.
module uart_tx_drain
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              fifo_empty,
   input  logic              fifo_wr,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_rd,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);

   localparam int BW = $clog2(DATA_W) + 1;

   state_e            state_q;
   logic [DATA_W-1:0] shift_q;
   logic [BW-1:0]     bit_q;
   logic              tx_q;
   logic              busy_q;
   logic              done_q;
   logic              run;
   logic              bit_end;
   logic              pre_end;
`ifdef UART_TX_PARITY_EN
   logic              par_q;
`endif

   // A read alongside a write would be dropped by the FIFO, so hold it off.
   assign fifo_rd = (state_q == IDLE) & en & ~fifo_empty & ~fifo_wr;
   assign run     = (state_q != IDLE) && (state_q != FETCH);
   assign tx      = tx_q;
   assign busy    = busy_q;
   assign tx_done = done_q;

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (~run),
      .run_i    (run),
      .bit_end_o(bit_end),
      .pre_end_o(pre_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         tx_q    <= LINE_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (fifo_rd) begin
                  state_q <= FETCH;
                  busy_q  <= 1'b1;
               end
            end
            FETCH: begin
               shift_q <= fifo_dout;
               bit_q   <= '0;
               tx_q    <= START_LVL;
               state_q <= START;
`ifdef UART_TX_PARITY_EN
               par_q   <= ^fifo_dout;
`endif
            end
            START: begin
               if (bit_end) begin
                  tx_q    <= shift_q[0];
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  shift_q <= shift_q >> 1;
                  if (bit_q == BW'(DATA_W - 1)) begin
                     bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
                     tx_q    <= par_q;
                     state_q <= PARITY;
`else
                     tx_q    <= LINE_IDLE;
                     state_q <= STOP;
`endif
                  end else begin
                     bit_q <= bit_q + 1'b1;
                     tx_q  <= shift_q[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  tx_q    <= LINE_IDLE;
                  state_q <= STOP;
               end
            end
`endif
            STOP: begin
               done_q <= pre_end;
               if (bit_end) begin
                  done_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= LINE_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with a FIFO model and byte scoreboard.
// Frame length follows UART_TX_PARITY_EN.
module tb_uart_tx_drain;

   localparam int C = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       fifo_empty = 1'b1;
   logic       fifo_wr = 1'b0;
   logic [7:0] fifo_dout = 8'h00;
   logic [7:0] wr_data = 8'h00;
   logic       fifo_rd;
   logic       tx;
   logic       busy;
   logic       tx_done;

   logic [7:0] fq[$];
   logic [7:0] sb[$];
   int         rd_cnt = 0;
   int         vec = 0;
   int         miss = 0;

   always #5 clk = ~clk;

   uart_tx_drain #(
      .CLKS_PER_BIT(C),
      .DATA_W      (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .fifo_empty(fifo_empty),
      .fifo_wr   (fifo_wr),
      .fifo_dout (fifo_dout),
      .fifo_rd   (fifo_rd),
      .tx        (tx),
      .busy      (busy),
      .tx_done   (tx_done)
   );

   // 16-deep FIFO model: write has priority, registered read data and empty flag
   always @(posedge clk) begin
      if (fifo_rd) rd_cnt <= rd_cnt + 1;
      if (fifo_wr) begin
         if (fq.size() < 16) fq.push_back(wr_data);
      end else if (fifo_rd) begin
         fifo_dout <= fq.pop_front();
      end
      fifo_empty <= (fq.size() == 0);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fifo_write(input logic [7:0] d);
      fifo_wr = 1'b1;
      wr_data = d;
      sb.push_back(d);
      @(negedge clk);
      fifo_wr = 1'b0;
   endtask

   task automatic wait_start(output int n);
      n = 0;
      while (tx !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic recv(input string tag, output int gap);
      logic       bits[NB];
      logic [7:0] d;
      logic [7:0] exp;
      int         glitch;
      int         pulses;
      int         dpos;
      int         blow;
      glitch = 0;
      pulses = 0;
      dpos   = -1;
      blow   = 0;
      wait_start(gap);
      chk({tag, " start seen"}, 32'(gap < 200), 1);
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      if (gap >= 200) return;
      for (int i = 0; i < NB * C; i++) begin
         if (i % C == 0) bits[i/C] = tx;
         else if (tx !== bits[i/C]) glitch++;
         if (tx_done === 1'b1) begin
            pulses++;
            dpos = i;
         end
         if (busy !== 1'b1) blow++;
         @(negedge clk);
      end
      for (int j = 0; j < 8; j++) d[j] = bits[1+j];
      chk({tag, " start bit"}, 32'(bits[0]), 0);
      chk({tag, " data"}, 32'(d), 32'(exp));
`ifdef UART_TX_PARITY_EN
      chk({tag, " parity"}, 32'(bits[9]), 32'(^exp));
`endif
      chk({tag, " stop bit"}, 32'(bits[NB-1]), 1);
      chk({tag, " bit stable"}, glitch, 0);
      chk({tag, " done pulses"}, pulses, 1);
      chk({tag, " done pos"}, dpos, NB * C - 1);
      chk({tag, " busy in frame"}, blow, 0);
      chk({tag, " idle after"}, {29'd0, tx, busy, tx_done}, 32'b100);
   endtask

   initial begin
      int n;
      int r0;
      int lows;
      int rds;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset outs", {28'd0, tx, busy, tx_done, fifo_rd}, 32'b1000);

      // single byte, latency and bit pattern
      fifo_write(8'hA5);
      en = 1'b1;
      #1;
      chk("t1 rd issue", 32'(fifo_rd), 1);
      @(negedge clk);
      chk("t1 fetch", {29'd0, fifo_rd, busy, tx}, 32'b011);
      @(negedge clk);
      chk("t1 tx fall N+2", 32'(tx), 0);
      recv("t1", n);
      chk("t1 rd count", rd_cnt, 1);
      chk("t1 fifo empty", 32'(fifo_empty), 1);

      // back-to-back frames with minimum gap
      r0 = rd_cnt;
      fifo_write(8'h00);
      fifo_write(8'hFF);
      recv("t2a", n);
      recv("t2b", n);
      chk("t2 gap", n, 2);
      chk("t2 rd count", rd_cnt - r0, 2);

      // reads held off while writes are in progress
      en = 1'b0;
      fifo_write(8'h11);
      en = 1'b1;
      r0 = rd_cnt;
      fifo_wr = 1'b1;
      wr_data = 8'h22;
      sb.push_back(8'h22);
      #1;
      chk("t3 hold 0", 32'(fifo_rd), 0);
      @(negedge clk);
      wr_data = 8'h33;
      sb.push_back(8'h33);
      #1;
      chk("t3 hold 1", 32'(fifo_rd), 0);
      @(negedge clk);
      wr_data = 8'h44;
      sb.push_back(8'h44);
      #1;
      chk("t3 hold 2", 32'(fifo_rd), 0);
      @(negedge clk);
      fifo_wr = 1'b0;
      #1;
      chk("t3 release", 32'(fifo_rd), 1);
      recv("t3a", n);
      recv("t3b", n);
      recv("t3c", n);
      recv("t3d", n);
      chk("t3 rd count", rd_cnt - r0, 4);

      // reset during data bit 3 aborts the frame
      fifo_write(8'h3C);
      void'(sb.pop_back());
      wait_start(n);
      chk("t4 start seen", 32'(n < 200), 1);
      repeat (4 * C) @(negedge clk);
      chk("t4 bit3", 32'(tx), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t4 after rst", {29'd0, tx, busy, tx_done}, 32'b100);
      lows = 0;
      for (int i = 0; i < 40; i++) begin
         if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) lows++;
         @(negedge clk);
      end
      chk("t4 quiet", lows, 0);

      // enable gating
      en = 1'b0;
      fifo_write(8'h55);
      lows = 0;
      rds = 0;
      for (int i = 0; i < 50; i++) begin
         if (tx !== 1'b1) lows++;
         if (fifo_rd !== 1'b0) rds++;
         @(negedge clk);
      end
      chk("t5 no rd", rds, 0);
      chk("t5 tx idle", lows, 0);
      en = 1'b1;
      wait_start(n);
      en = 1'b0;
      recv("t5a", n);
      fifo_write(8'h66);
      rds = 0;
      for (int i = 0; i < 20; i++) begin
         if (fifo_rd !== 1'b0) rds++;
         @(negedge clk);
      end
      chk("t5 hold", rds, 0);
      en = 1'b1;
      recv("t5b", n);

      // odd-parity data byte
      fifo_write(8'h07);
      recv("t6", n);
      chk("end fifo empty", 32'(fifo_empty), 1);
      chk("end scoreboard", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
